// File: rtl/fp_pkg.sv
// Shared FP datapath types: rounding-mode encoding and exponent-adjust width helper.
package fp_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_e;

  // Signed adjust must reach +1 and -(mant_w+1).
  function automatic int adj_width(input int mant_w);
    return $clog2(mant_w) + 2;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; cnt equals W when the input is all zero.
module fp_lzc #(
  parameter int W  = 49,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt,
  output logic          all_zero
);

  // Scan upward so the highest set bit gives the final count.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      cnt = din[i] ? CW'(W - 1 - i) : cnt;
    end
    all_zero = (din == {W{1'b0}});
  end

endmodule

// File: rtl/fp_mant_addsub_pipe.sv
// Two-stage mantissa add/sub and normalise unit for the FP adder tail.
// Stage 1 forms the magnitude sum and sign; stage 2 normalises into the output registers.
module fp_mant_addsub_pipe
  import fp_pkg::*;
#(
  parameter int MANT_W = 48,
  parameter int TAG_W  = 5,
  parameter int ADJ_W  = adj_width(MANT_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  input  logic              sticky_in,
  input  rm_e               rm,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              res_sign,
  output logic [MANT_W-1:0] res_mant,
  output logic [ADJ_W-1:0]  exp_adj,
  output logic              sticky_out,
  output logic              res_zero,
  output logic [TAG_W-1:0]  tag_out
);

  localparam int EW   = MANT_W + 2;
  localparam int LZ_W = $clog2(MANT_W + 2);

  logic              rdy_en_r;
  logic              s1_v_r;
  logic              s2_v_r;
  logic [EW-1:0]     s1_sum_r;
  logic              s1_sign_r;
  logic              s1_zsign_r;
  logic              s1_stk_r;
  logic [TAG_W-1:0]  s1_tag_r;

  logic              s2_adv_s;
  logic              s1_adv_s;
  logic              accept_s;
  logic [EW-1:0]     ea_s;
  logic [EW-1:0]     eb_s;
  logic [EW-1:0]     sum_s;
  logic              sign_s;
  logic              zsign_s;

  logic              carry_s;
  logic [LZ_W-1:0]   lzc_s;
  logic              lz_all_zero_s;
  logic              zero_s;
  logic [MANT_W:0]   shl_s;
  logic [MANT_W-1:0] mant_s;
  logic [ADJ_W-1:0]  adj_s;
  logic              stk_s;
  logic              sign2_s;

  assign s2_adv_s = ~s2_v_r | out_ready;
  assign s1_adv_s = ~s1_v_r | s2_adv_s;
  assign in_ready = rdy_en_r & ~flush & s1_adv_s;
  assign accept_s = in_valid & in_ready;
  assign out_valid = s2_v_r;

  // Effective add/subtract on the extended operands; sticky rides in eb's LSB.
  always_comb begin
    ea_s    = {1'b0, mant_a, 1'b0};
    eb_s    = {1'b0, mant_b, sticky_in};
    zsign_s = (sign_a != sign_b) ? (rm == RDN) : sign_a;
    if (sign_a == sign_b) begin
      sum_s  = ea_s + eb_s;
      sign_s = sign_a;
    end else if (ea_s >= eb_s) begin
      sum_s  = ea_s - eb_s;
      sign_s = sign_a;
    end else begin
      sum_s  = eb_s - ea_s;
      sign_s = sign_b;
    end
  end

  // in_ready stays low for the first cycle after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_r     <= 1'b0;
      s1_sum_r   <= {EW{1'b0}};
      s1_sign_r  <= 1'b0;
      s1_zsign_r <= 1'b0;
      s1_stk_r   <= 1'b0;
      s1_tag_r   <= {TAG_W{1'b0}};
    end else if (flush) begin
      s1_v_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_v_r <= accept_s;
      if (accept_s) begin
        s1_sum_r   <= sum_s;
        s1_sign_r  <= sign_s;
        s1_zsign_r <= zsign_s;
        s1_stk_r   <= sticky_in;
        s1_tag_r   <= tag_in;
      end
    end
  end

  fp_lzc #(.W(MANT_W + 1), .CW(LZ_W)) u_lzc (
    .din      (s1_sum_r[MANT_W:0]),
    .cnt      (lzc_s),
    .all_zero (lz_all_zero_s)
  );

  assign carry_s = s1_sum_r[EW-1];
  assign zero_s  = ~carry_s & lz_all_zero_s & ~s1_stk_r;

  // Normalise: right by one on carry-out, otherwise left by the leading-zero count.
  always_comb begin
    shl_s = s1_sum_r[MANT_W:0] << lzc_s;
    if (zero_s) begin
      mant_s  = {MANT_W{1'b0}};
      adj_s   = {ADJ_W{1'b0}};
      stk_s   = 1'b0;
      sign2_s = s1_zsign_r;
    end else if (carry_s) begin
      mant_s  = s1_sum_r[EW-1:2];
      adj_s   = {{(ADJ_W-1){1'b0}}, 1'b1};
      stk_s   = s1_stk_r | (|s1_sum_r[1:0]);
      sign2_s = s1_sign_r;
    end else begin
      mant_s  = shl_s[MANT_W:1];
      adj_s   = {ADJ_W{1'b0}} - ADJ_W'(lzc_s);
      stk_s   = s1_stk_r | shl_s[0];
      sign2_s = s1_sign_r;
    end
  end

  // Stage 2 registers drive the outputs directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_v_r     <= 1'b0;
      res_sign   <= 1'b0;
      res_mant   <= {MANT_W{1'b0}};
      exp_adj    <= {ADJ_W{1'b0}};
      sticky_out <= 1'b0;
      res_zero   <= 1'b0;
      tag_out    <= {TAG_W{1'b0}};
    end else if (flush) begin
      s2_v_r <= 1'b0;
    end else if (s2_adv_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        res_sign   <= sign2_s;
        res_mant   <= mant_s;
        exp_adj    <= adj_s;
        sticky_out <= stk_s;
        res_zero   <= zero_s;
        tag_out    <= s1_tag_r;
      end
    end
  end

endmodule
